// File: rtl/axi_mem_arbiter.sv
// axi_mem_arbiter
// Shares one single-port synchronous memory between the AXI write group
// (AW/W/B) and the read group (AR/R). Round-robin arbitration between bursts,
// beat-by-beat memory sequencing, and B/R response generation.
module axi_mem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int ID_W   = 4,
  parameter int LEN_W  = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_awvalid,
  output logic              o_awready,
  input  logic [ADDR_W-1:0] i_awaddr,
  input  logic [ID_W-1:0]   i_awid,
  input  logic [LEN_W-1:0]  i_awlen,
  input  logic              i_wvalid,
  output logic              o_wready,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_wlast,
  output logic              o_bvalid,
  input  logic              i_bready,
  output logic [ID_W-1:0]   o_bid,
  output logic [1:0]        o_bresp,
  input  logic              i_arvalid,
  output logic              o_arready,
  input  logic [ADDR_W-1:0] i_araddr,
  input  logic [ID_W-1:0]   i_arid,
  input  logic [LEN_W-1:0]  i_arlen,
  output logic              o_rvalid,
  input  logic              i_rready,
  output logic [DATA_W-1:0] o_rdata,
  output logic [ID_W-1:0]   o_rid,
  output logic [1:0]        o_rresp,
  output logic              o_rlast,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    WR_DATA,
    WR_RESP,
    RD_ISSUE,
    RD_DATA
  } state_t;

  localparam logic       GRANT_READ  = 1'b0;
  localparam logic       GRANT_WRITE = 1'b1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  state_t              r_state;
  state_t              w_next_state;
  logic                r_last_grant;
  logic [ADDR_W-1:0]   r_cur_addr;
  logic [ID_W-1:0]     r_id;
  logic [LEN_W-1:0]    r_len;
  logic [LEN_W-1:0]    r_cnt;
  logic [1:0]          r_bresp;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_rd_first;
  logic                w_cnt_last;
  logic                w_wr_end;
  logic [1:0]          w_wr_bresp;

  assign w_cnt_last = (r_cnt == r_len);
  assign o_rresp    = 2'b00;

  // Next-state decode and all combinational outputs; everything is forced low
  // while reset is asserted so no grant or memory write leaks out in that cycle.
  always_comb begin
    w_next_state = r_state;
    o_awready    = 1'b0;
    o_arready    = 1'b0;
    o_wready     = 1'b0;
    o_bvalid     = 1'b0;
    o_bid        = '0;
    o_bresp      = 2'b00;
    o_rvalid     = 1'b0;
    o_rid        = '0;
    o_rlast      = 1'b0;
    o_rdata      = r_rdata;
    o_mem_en     = 1'b0;
    o_mem_we     = 1'b0;
    o_mem_addr   = '0;
    o_mem_wdata  = '0;
    w_wr_end     = 1'b0;
    w_wr_bresp   = RESP_OKAY;
    if (i_rst) begin
      o_rdata = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_awvalid && (!i_arvalid || (r_last_grant == GRANT_READ))) begin
            o_awready    = 1'b1;
            w_next_state = WR_DATA;
          end else if (i_arvalid) begin
            o_arready    = 1'b1;
            w_next_state = RD_ISSUE;
          end
        end
        WR_DATA: begin
          o_wready = 1'b1;
          if (i_wvalid) begin
            o_mem_en    = 1'b1;
            o_mem_we    = 1'b1;
            o_mem_addr  = r_cur_addr;
            o_mem_wdata = i_wdata;
            if (w_cnt_last || i_wlast) begin
              w_wr_end     = 1'b1;
              w_wr_bresp   = (w_cnt_last && i_wlast) ? RESP_OKAY : RESP_SLVERR;
              w_next_state = WR_RESP;
            end
          end
        end
        WR_RESP: begin
          o_bvalid = 1'b1;
          o_bid    = r_id;
          o_bresp  = r_bresp;
          if (i_bready) begin
            w_next_state = IDLE;
          end
        end
        RD_ISSUE: begin
          o_mem_en     = 1'b1;
          o_mem_addr   = r_cur_addr;
          w_next_state = RD_DATA;
        end
        RD_DATA: begin
          o_rvalid = 1'b1;
          o_rid    = r_id;
          o_rlast  = w_cnt_last;
          if (r_rd_first) begin
            o_rdata = i_mem_rdata;
          end
          if (i_rready) begin
            w_next_state = w_cnt_last ? IDLE : RD_ISSUE;
          end
        end
        default: begin
          w_next_state = IDLE;
        end
      endcase
    end
  end

  // State register plus burst bookkeeping: latch the request on the address
  // handshake, advance address/count per beat, and hold read data until RREADY.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_last_grant <= GRANT_READ;
      r_cur_addr   <= '0;
      r_id         <= '0;
      r_len        <= '0;
      r_cnt        <= '0;
      r_bresp      <= RESP_OKAY;
      r_rdata      <= '0;
      r_rd_first   <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_rd_first <= (r_state == RD_ISSUE);
      if (o_awready) begin
        r_cur_addr   <= i_awaddr;
        r_id         <= i_awid;
        r_len        <= i_awlen;
        r_cnt        <= '0;
        r_last_grant <= GRANT_WRITE;
      end else if (o_arready) begin
        r_cur_addr   <= i_araddr;
        r_id         <= i_arid;
        r_len        <= i_arlen;
        r_cnt        <= '0;
        r_last_grant <= GRANT_READ;
      end
      if ((r_state == WR_DATA) && i_wvalid) begin
        r_cur_addr <= r_cur_addr + ADDR_W'(1);
        r_cnt      <= r_cnt + LEN_W'(1);
        if (w_wr_end) begin
          r_bresp <= w_wr_bresp;
        end
      end
      if ((r_state == RD_DATA) && r_rd_first) begin
        r_rdata <= i_mem_rdata;
      end
      if ((r_state == RD_DATA) && i_rready && !w_cnt_last) begin
        r_cur_addr <= r_cur_addr + ADDR_W'(1);
        r_cnt      <= r_cnt + LEN_W'(1);
      end
    end
  end

endmodule
